// File: rtl/raster_pkg.sv
//------------------------------------------------------------------------------
// Module   : raster_pkg
// Brief    : Shared widths, FSM state type and edge-accumulator helpers for the
//            raster_traverse triangle traversal stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package raster_pkg;

  localparam int EW = 22;  // signed edge accumulator width
  localparam int XW = 9;   // x coordinate width
  localparam int YW = 8;   // y coordinate width
  localparam int CW = 10;  // edge coefficient width (a, b)
  localparam int KW = 18;  // edge constant width (c)

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ROW0 = 3'd2,
    SCAN = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef logic signed [EW-1:0] edge_acc_t;

  function automatic edge_acc_t sext_coef(input logic [CW-1:0] v);
    return edge_acc_t'({{(EW-CW){v[CW-1]}}, v});
  endfunction

  function automatic edge_acc_t sext_const(input logic [KW-1:0] v);
    return edge_acc_t'({{(EW-KW){v[KW-1]}}, v});
  endfunction

  function automatic edge_acc_t zext_x(input logic [XW-1:0] v);
    return edge_acc_t'({{(EW-XW){1'b0}}, v});
  endfunction

  function automatic edge_acc_t zext_y(input logic [YW-1:0] v);
    return edge_acc_t'({{(EW-YW){1'b0}}, v});
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_stepper.sv
//------------------------------------------------------------------------------
// Module   : edge_stepper
// Brief    : Incremental evaluator for one edge function; holds the current
//            value E and the row-start value R, and reports the sign of E.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_stepper
  import raster_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic signed [EW-1:0] init_i,
  input  logic [CW-1:0]        a_i,
  input  logic [CW-1:0]        b_i,
  input  logic                 step_x_i,
  input  logic                 step_row_i,
  input  logic                 stall_i,
  output logic                 ge_o,
  output logic                 le_o
);

  edge_acc_t e_q;
  edge_acc_t r_q;
  edge_acc_t w_a;
  edge_acc_t w_b;

  assign w_a = sext_coef(a_i);
  assign w_b = sext_coef(b_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q <= '0;
      r_q <= '0;
    end else if (load_i) begin
      e_q <= init_i;
      r_q <= init_i;
    end else if (!stall_i) begin
      if (step_x_i) begin
        e_q <= e_q + w_a;
      end else if (step_row_i) begin
        // Next row restarts from the row-start value, not from the row end.
        r_q <= r_q + w_b;
        e_q <= r_q + w_b;
      end
    end
  end

  assign ge_o = ~e_q[EW-1];
  assign le_o = e_q[EW-1] | (e_q == '0);

endmodule

`default_nettype wire

// File: rtl/raster_traverse.sv
//------------------------------------------------------------------------------
// Module   : raster_traverse
// Brief    : Row-major bounding-box walker emitting covered pixels over a
//            valid/ready handshake. RASTER_BOTH_WINDING_EN also accepts
//            all-non-positive edge values (either triangle winding).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module raster_traverse
  import raster_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          raster_start,
  input  logic [CW-1:0] a1,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] a2,
  input  logic [CW-1:0] b2,
  input  logic [CW-1:0] a3,
  input  logic [CW-1:0] b3,
  input  logic [KW-1:0] c1,
  input  logic [KW-1:0] c2,
  input  logic [KW-1:0] c3,
  input  logic [XW-1:0] bbxi,
  input  logic [XW-1:0] bbxf,
  input  logic [YW-1:0] bbyi,
  input  logic [YW-1:0] bbyf,
  output logic          busy,
  output logic          raster_done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y
);

`ifdef RASTER_BOTH_WINDING_EN
  localparam logic c_both_winding = 1'b1;
`else
  localparam logic c_both_winding = 1'b0;
`endif

  state_t               state_q;
  logic                 busy_q;
  logic                 raster_done_q;
  logic                 pix_valid_q;
  logic [XW-1:0]        pix_x_q;
  logic [YW-1:0]        pix_y_q;
  logic [XW-1:0]        cx_q;
  logic [YW-1:0]        cy_q;
  logic                 last_q;
  logic [2:0][CW-1:0]   a_q;
  logic [2:0][CW-1:0]   b_q;
  logic [2:0][KW-1:0]   c_q;
  logic [XW-1:0]        bbxi_q;
  logic [XW-1:0]        bbxf_q;
  logic [YW-1:0]        bbyi_q;
  logic [YW-1:0]        bbyf_q;

  logic                 w_stall;
  logic                 w_test;
  logic                 w_x_end;
  logic                 w_y_end;
  logic                 w_step_x;
  logic                 w_step_row;
  logic                 w_load;
  logic [2:0]           w_ge;
  logic [2:0]           w_le;
  logic                 w_cov;

  assign w_stall    = pix_valid_q & ~pix_ready;
  assign w_test     = (state_q == SCAN) & ~last_q;
  assign w_x_end    = (cx_q == bbxf_q);
  assign w_y_end    = (cy_q == bbyf_q);
  assign w_step_x   = w_test & ~w_x_end;
  assign w_step_row = w_test & w_x_end & ~w_y_end;
  assign w_load     = (state_q == ROW0);
  assign w_cov      = (&w_ge) | (c_both_winding & (&w_le));

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    edge_acc_t pax_q;
    edge_acc_t pby_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        pax_q <= '0;
        pby_q <= '0;
      end else if (state_q == MUL) begin
        pax_q <= sext_coef(a_q[gi]) * zext_x(bbxi_q);
        pby_q <= sext_coef(b_q[gi]) * zext_y(bbyi_q);
      end
    end

    edge_stepper u_edge (
      .clk        (clk),
      .rst        (rst),
      .load_i     (w_load),
      .init_i     (pax_q + pby_q + sext_const(c_q[gi])),
      .a_i        (a_q[gi]),
      .b_i        (b_q[gi]),
      .step_x_i   (w_step_x),
      .step_row_i (w_step_row),
      .stall_i    (w_stall),
      .ge_o       (w_ge[gi]),
      .le_o       (w_le[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      raster_done_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      last_q        <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      bbxi_q        <= '0;
      bbxf_q        <= '0;
      bbyi_q        <= '0;
      bbyf_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          raster_done_q <= 1'b0;
          if (raster_start) begin
            a_q     <= {a3, a2, a1};
            b_q     <= {b3, b2, b1};
            c_q     <= {c3, c2, c1};
            bbxi_q  <= bbxi;
            bbxf_q  <= bbxf;
            bbyi_q  <= bbyi;
            bbyf_q  <= bbyf;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: state_q <= ROW0;
        ROW0: begin
          cx_q    <= bbxi_q;
          cy_q    <= bbyi_q;
          last_q  <= 1'b0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (!w_stall) begin
            if (!last_q) begin
              pix_valid_q <= w_cov;
              pix_x_q     <= cx_q;
              pix_y_q     <= cy_q;
              // End test precedes the increment so the box edge never wraps.
              if (!w_x_end) begin
                cx_q <= cx_q + 1'b1;
              end else if (!w_y_end) begin
                cx_q <= bbxi_q;
                cy_q <= cy_q + 1'b1;
              end else begin
                last_q <= 1'b1;
              end
            end else begin
              pix_valid_q   <= 1'b0;
              raster_done_q <= 1'b1;
              state_q       <= DONE;
            end
          end
        end
        DONE: begin
          raster_done_q <= 1'b0;
          busy_q        <= 1'b0;
          last_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign raster_done = raster_done_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule

`default_nettype wire

// File: tb/tb_raster_traverse.sv
//------------------------------------------------------------------------------
// Module   : tb_raster_traverse
// Brief    : Self-checking bench for raster_traverse against a coverage model
//            that evaluates the edge functions directly for every box pixel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_raster_traverse;

  logic       clk = 1'b0;
  logic       rst;
  logic       raster_start;
  logic [9:0] a1, b1, a2, b2, a3, b3;
  logic [17:0] c1, c2, c3;
  logic [8:0] bbxi, bbxf;
  logic [7:0] bbyi, bbyf;
  logic       pix_ready;
  wire        busy, raster_done, pix_valid;
  wire  [8:0] pix_x;
  wire  [7:0] pix_y;

  always #5 clk = ~clk;

  raster_traverse dut (
    .clk(clk), .rst(rst), .raster_start(raster_start),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .busy(busy), .raster_done(raster_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  int ta[3], tbc[3], tc[3];
  int bx0, bx1, by0, by1;
  logic [16:0] exp_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0, done_cnt = 0, busy_cyc = 0;
  int first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  bit first_seen = 1'b0;
  bit chk_en = 1'b0, tog = 1'b0;
  bit prev_stall = 1'b0;
  logic [16:0] prev_xy = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference coverage: direct evaluation of a*x+b*y+c at every box pixel.
  task automatic build_expected();
    exp_q.delete();
    for (int y = by0; y <= by1; y++) begin
      for (int x = bx0; x <= bx1; x++) begin
        bit pos = 1'b1;
        bit neg = 1'b1;
        bit cov;
        for (int i = 0; i < 3; i++) begin
          int e;
          e = ta[i] * x + tbc[i] * y + tc[i];
          if (e < 0) pos = 1'b0;
          if (e > 0) neg = 1'b0;
        end
`ifdef RASTER_BOTH_WINDING_EN
        cov = pos | neg;
`else
        cov = pos;
`endif
        if (cov) exp_q.push_back({x[8:0], y[7:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst || !chk_en) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (prev_stall) begin
        chk("stall_valid", int'(pix_valid), 1);
        chk("stall_xy", int'({pix_x, pix_y}), int'(prev_xy));
      end
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_pix: got (%0d,%0d), expected no pixel", pix_x, pix_y);
        end else begin
          chk("pix_xy", int'({pix_x, pix_y}), int'(exp_q[0]));
          if (pix_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            if (!first_seen) begin
              first_seen = 1'b1;
              first_x = int'(pix_x);
              first_y = int'(pix_y);
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
          end
        end
      end
      if (raster_done) begin
        chk("done_with_valid", int'(pix_valid), 0);
        done_cnt++;
      end
      prev_stall = pix_valid & ~pix_ready;
      prev_xy    = {pix_x, pix_y};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) pix_ready = ~pix_ready;
    end
  end

  task automatic drive_inputs();
    a1 = ta[0][9:0];  b1 = tbc[0][9:0]; c1 = tc[0][17:0];
    a2 = ta[1][9:0];  b2 = tbc[1][9:0]; c2 = tc[1][17:0];
    a3 = ta[2][9:0];  b3 = tbc[2][9:0]; c3 = tc[2][17:0];
    bbxi = bx0[8:0];  bbxf = bx1[8:0];
    bbyi = by0[7:0];  bbyf = by1[7:0];
  endtask

  task automatic scramble_inputs();
    a1 = 10'($urandom()); b1 = 10'($urandom()); c1 = 18'($urandom());
    a2 = 10'($urandom()); b2 = 10'($urandom()); c2 = 18'($urandom());
    a3 = 10'($urandom()); b3 = 10'($urandom()); c3 = 18'($urandom());
    bbxi = 9'($urandom()); bbxf = 9'($urandom());
    bbyi = 8'($urandom()); bbyf = 8'($urandom());
  endtask

  task automatic set_tri(input int sgn);
    ta  = '{0, sgn, -sgn};
    tbc = '{sgn, 0, -sgn};
    tc  = '{0, 0, 4 * sgn};
    bx0 = 0; bx1 = 4; by0 = 0; by1 = 4;
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run(input bit toggle, input int restart_at, input int budget);
    int d0;
    build_expected();
    drive_inputs();
    first_seen = 1'b0;
    busy_cyc   = 0;
    d0         = done_cnt;
    chk_en     = 1'b1;
    raster_start = 1'b1;
    @(posedge clk);
    #1;
    raster_start = 1'b0;
    scramble_inputs();
    tog = toggle;
    chk("busy_after_start", int'(busy), 1);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) break;
      raster_start = (k == restart_at);
    end
    raster_start = 1'b0;
    tog = 1'b0;
    pix_ready = 1'b1;
    if (done_cnt == d0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no raster_done, expected one within %0d cycles", budget);
    end else begin
      chk("busy_after_done", int'(busy), 0);
    end
    chk("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    int n0, d0;
    bit hit;
    rst = 1'b0;
    raster_start = 1'b0;
    pix_ready = 1'b1;
    set_tri(1);
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(raster_done), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Model pin: x>=0, y>=0, x+y<=4 in a 5x5 box holds 15 pixels.
    set_tri(1);
    build_expected();
    chk("model_size", exp_q.size(), 15);
    chk("model_last", int'(exp_q[exp_q.size()-1]), 4);

    n0 = acc_cnt;
    run(1'b0, -1, 200);
    chk("t1_count", acc_cnt - n0, 15);
    chk("t1_busy_cycles", busy_cyc, 29);
    chk("t1_first", first_x * 256 + first_y, 0);
    chk("t1_last", last_x * 256 + last_y, 4);

    set_tri(-1);
    n0 = acc_cnt;
    run(1'b0, -1, 200);
`ifdef RASTER_BOTH_WINDING_EN
    chk("t2_count", acc_cnt - n0, 15);
`else
    chk("t2_count", acc_cnt - n0, 0);
`endif
    chk("t2_busy_cycles", busy_cyc, 29);

    set_tri(1);
    n0 = acc_cnt;
    run(1'b1, -1, 400);
    chk("t3_count", acc_cnt - n0, 15);
    chk("t3_first", first_x * 256 + first_y, 0);

    ta = '{0, 0, 0}; tbc = '{0, 0, 0}; tc = '{1, 1, 1};
    bx0 = 511; bx1 = 511; by0 = 255; by1 = 255;
    n0 = acc_cnt;
    run(1'b0, -1, 50);
    chk("t4_count", acc_cnt - n0, 1);
    chk("t4_pixel", first_x * 256 + first_y, 511 * 256 + 255);
    chk("t4_busy_cycles", busy_cyc, 5);

    // Abort after the fifth accepted pixel.
    set_tri(1);
    build_expected();
    drive_inputs();
    n0 = acc_cnt;
    d0 = done_cnt;
    raster_start = 1'b1;
    @(posedge clk);
    #1;
    raster_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (acc_cnt - n0 >= 5) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("abort_reached5", int'(hit), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", int'(pix_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(raster_done), 0);
    exp_q.delete();
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    set_tri(1);
    n0 = acc_cnt;
    run(1'b0, -1, 200);
    chk("t6_count", acc_cnt - n0, 15);
    chk("t6_busy_cycles", busy_cyc, 29);

    n0 = acc_cnt;
    run(1'b0, 6, 200);
    chk("t7_count", acc_cnt - n0, 15);
    chk("t7_last", last_x * 256 + last_y, 4);
    chk("t7_busy_cycles", busy_cyc, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/raster_traverse.md
Name: raster_traverse

Overview:
- Triangle traversal stage that sits directly downstream of the edge-equation/bounding-box stage.
- Walks the bounding box row-major: x from bbxi to bbxf, then y from bbyi to bbyf.
- Evaluates all three edge functions incrementally and emits the (x,y) of every covered pixel to the pixel-write stage over a valid/ready handshake.
- Processes one candidate pixel per cycle when downstream is not stalling.

Parameters:
- EW, 22, signed edge-accumulator width (a*x + b*y + c worst case is 21 bits, plus 1 guard bit).
- XW, 9, x coordinate width.
- YW, 8, y coordinate width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- raster_start  in  1  one-cycle pulse: coefficients and box valid this cycle
- a1,b1,a2,b2,a3,b3  in  10 signed  edge coefficients
- c1,c2,c3  in  18 signed  edge constants
- bbxi,bbxf  in  9  bounding box x min/max (unsigned)
- bbyi,bbyf  in  8  bounding box y min/max (unsigned)
- busy  out  1  high from accepted start until done
- raster_done  out  1  one-cycle pulse, traversal finished
- pix_valid  out  1  covered pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  9  pixel x
- pix_y  out  8  pixel y

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; busy, raster_done and pix_valid are 0; pix_x and pix_y are 0; all accumulators are 0.
- Reset mid-traversal aborts immediately. No raster_done pulse is produced, and no further pixels are emitted.
- raster_start is honoured only in IDLE; it is ignored while busy.
  - On acceptance, latch all coefficients and the box. Inputs may change afterward.
- FSM states: IDLE -> MUL -> ROW0 -> SCAN -> DONE -> IDLE.
  - MUL, 1 cycle: register the products a_i*bbxi and b_i*bbyi. Box values are zero-extended to signed.
  - ROW0, 1 cycle: E_i = a_i*bbxi + b_i*bbyi + c_i, sign-extended to EW. Copy E_i to the row-start register R_i. Set cx=bbxi, cy=bbyi.
  - SCAN: each advancing cycle tests the current (cx,cy).
    - Covered iff E1>=0, E2>=0 and E3>=0.
    - If covered, present pix_valid=1 with pix_x=cx and pix_y=cy (registered outputs).
    - Step when cx<bbxf: cx+=1, E_i+=a_i.
    - Step when cx==bbxf and cy<bbyf: cx=bbxi, cy+=1, R_i+=b_i, E_i=R_i+b_i.
    - Step when cx==bbxf and cy==bbyf: go to DONE after the last pixel is accepted.
  - DONE, 1 cycle: raster_done=1, busy=0 next cycle, return to IDLE.
- Back-pressure:
  - While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_valid hold, and traversal stalls. No stepping and no accumulator update occur.
  - Uncovered candidates never stall.
- Latency:
  - start accepted at edge T; first candidate tested in the cycle after T+2.
  - First possible pix_valid=1 appears after edge T+3.
  - Total cycles with no stall = 3 + box_area + 1.
- Boundary cases:
  - Single-pixel box (bbxi==bbxf, bbyi==bbyf): exactly one candidate.
  - bbxf=511, bbyf=255: coordinates never wrap, because the end comparison precedes the increment.
  - Degenerate triangle (all a,b,c=0): every box pixel has E=0 and is emitted.
  - pix_valid and raster_done are never high in the same cycle.
- Arithmetic: all accumulations are signed EW-bit and must never overflow for in-range inputs. No saturation is applied.

Optional Feature:
- Macro: RASTER_BOTH_WINDING_EN.
- When defined: a pixel is also covered when E1<=0, E2<=0 and E3<=0. This accepts clockwise and counter-clockwise triangles.
- When undefined: only all->=0 counts. Opposite-winding triangles emit zero pixels, but still pulse raster_done.

Decomposition:
- raster_pkg holds:
  - constants EW, XW and YW;
  - the state enum typedef (IDLE, MUL, ROW0, SCAN, DONE);
  - typedef edge_acc_t (signed EW-bit).
- One sub-module, edge_stepper, instantiated 3x. It holds E and R for one edge.
  - Inputs: init value, a, b, step_x, step_row, stall.
  - Outputs: E and the sign flags (E>=0, E<=0).

Test Plan:
- v1(0,0), v2(4,0), v3(0,4), box 0..4 x 0..4, pix_ready=1 -> exactly 15 pixels, all with x+y<=4, in row-major order. raster_done arrives 3+25+1 cycles after start.
- Same triangle with v2 and v3 swapped -> 0 pixels and raster_done without the macro; the same 15 pixels with RASTER_BOTH_WINDING_EN.
- First triangle with pix_ready toggling 0/1 every cycle -> identical 15-pixel sequence, and pix_x/pix_y stable during every stall.
- Single-pixel box at (511,255) with coefficients a=b=0, c=1 -> one pixel (511,255), no wrap, raster_done follows.
- Assert rst=0 after the 5th emitted pixel -> pix_valid, busy and raster_done go to 0 next cycle, no done pulse. A new raster_start then runs normally.
- Pulse raster_start again while busy -> ignored, and the original sequence completes unchanged.
